vpu_writeback_deskew: RTL and testbench
=======================================

Name: vpu_writeback_deskew

Overview:
- Downstream of the two-column leaky-ReLU stage. Consumes its per-column outputs, which arrive skewed by the systolic wavefront.
- Pairs element k of column 1 with element k of column 2 into one row word.
- Streams row words to the unified buffer over a valid/ready interface, with an auto-incrementing address.
- Signals completion after a programmed number of rows.

Parameters:
- DATA_WIDTH, 16, width of one column sample (signed fixed-point, passed through unmodified).
- ADDR_WIDTH, 8, unified-buffer address width; also the width of the row counter.
- DEPTH, 4, entries per column FIFO (power of two, at least 2).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- wb_start_in  in  1  one-cycle pulse: latch base address and row count, enter RUN.
- wb_base_addr_in  in  ADDR_WIDTH  first write address, sampled on start.
- wb_row_count_in  in  ADDR_WIDTH  rows to write, sampled on start.
- wb_valid_1_in  in  1  column-1 sample valid.
- wb_data_1_in  in  DATA_WIDTH  column-1 sample.
- wb_valid_2_in  in  1  column-2 sample valid.
- wb_data_2_in  in  DATA_WIDTH  column-2 sample.
- wb_ready_in  in  1  unified buffer accepts the current word.
- wb_valid_out  out  1  row word valid.
- wb_data_out  out  2*DATA_WIDTH  {column2, column1}; column 1 in the LSBs.
- wb_addr_out  out  ADDR_WIDTH  write address of the current word.
- wb_busy_out  out  1  high in RUN.
- wb_done_out  out  1  one-cycle pulse when the job completes.
- wb_overflow_out  out  1  sticky flag: a sample was dropped.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE; both FIFOs empty; row index 0.
  - All outputs 0 (wb_valid_out, wb_data_out, wb_addr_out, wb_busy_out, wb_done_out, wb_overflow_out).
  - Reset mid-job abandons the job; nothing is retained.
- FSM IDLE -> RUN:
  - On wb_start_in with count != 0: latch base and count; clear the index, both FIFOs and the overflow flag; wb_busy_out=1 from the next cycle.
  - On wb_start_in with count == 0: no RUN; wb_done_out pulses the next cycle; overflow is cleared.
- FSM RUN -> IDLE:
  - Occurs in the cycle after the handshake (wb_valid_out & wb_ready_in) for index == count-1.
  - wb_done_out=1 for exactly that one cycle; wb_busy_out=0 the same cycle.
  - Any residual FIFO contents are flushed.
- wb_start_in during RUN is ignored.
- Input capture:
  - Valid samples are accepted only in RUN; in IDLE they are discarded silently and the overflow flag does not change.
  - Each column has its own DEPTH-entry FIFO. Arbitrary skew between columns is tolerated up to DEPTH.
  - A push is accepted if the FIFO is not full, or if it is full and is being popped in the same cycle.
  - Otherwise the sample is dropped and wb_overflow_out is set. It stays set until the next start or reset.
- Pairing and output:
  - A pair is popped when both FIFOs are non-empty AND the output register is empty or being handshaked this cycle.
  - Output register: loaded with {fifo2 head, fifo1 head}, wb_addr_out = base + index (modulo 2^ADDR_WIDTH wrap), and wb_valid_out=1.
  - The index increments on each handshake.
  - While wb_valid_out=1 and wb_ready_in=0, wb_data_out and wb_addr_out hold stable.
  - Back-to-back throughput is one row per cycle when wb_ready_in is held high.
- Latency:
  - Column-2 sample pushed at cycle t (its column-1 partner already present) gives wb_valid_out=1 at cycle t+1.
  - Typical case: col1 at cycle 0, col2 at cycle 1 -> output at cycle 2.
- No arithmetic on data; samples are passed bit-exact. The output word packs column 1 in the LSBs.

Test Plan:
- Reset mid-job: start base=0x10, count=4; push 2 pairs; assert rst=0 -> all outputs 0 immediately. Release rst -> IDLE; a later input valid gives no output.
- Skewed stream: start base=0x20, count=3, wb_ready_in=1. col1 = 0x0001, 0x0002, 0x0003 on cycles 0-2; col2 = 0xFFFF, 0x8000, 0x7FFF on cycles 1-3.
  - Words 0xFFFF0001@0x20, 0x80000002@0x21, 0x7FFF0003@0x22 on cycles 2-4.
  - wb_done_out pulses at cycle 5; busy drops at cycle 5.
- Backpressure: same stream with wb_ready_in=0 for cycles 2-6 -> word 0xFFFF0001@0x20 held stable throughout; all 3 words still delivered in order once ready returns; overflow stays 0.
- Overflow: DEPTH=4, wb_ready_in=0. Push 5 col1 samples and no col2 -> wb_overflow_out=1 from the cycle after the 5th push. Sticky until the next start.
- Address wrap and zero count:
  - base=0xFE, count=3 -> addresses 0xFE, 0xFF, 0x00.
  - start with count=0 -> wb_done_out pulses the next cycle; busy never asserts.
- IDLE and start-in-RUN: valids in IDLE produce no output and no overflow. wb_start_in during RUN with a new base=0x50 is ignored; addresses continue from the original base.

Source files
------------

// File: rtl/vpu_writeback_deskew.sv
// vpu_writeback_deskew
// Re-aligns the two skewed column streams from the leaky-ReLU stage into
// row words and writes them to the unified buffer at auto-incrementing
// addresses. Each column is buffered in its own small FIFO. A row is formed
// when both columns have an element available.
//
// Ports:
//   clk, rst            clock / asynchronous active-low reset
//   wb_start_in         start pulse; samples wb_base_addr_in / wb_row_count_in
//   wb_valid_N_in/data  column N sample stream (N = 1, 2)
//   wb_ready_in         unified buffer accepts the current row word
//   wb_valid_out        row word valid
//   wb_data_out         {column2, column1}
//   wb_addr_out         write address of the current row word
//   wb_busy_out         job in progress
//   wb_done_out         one-cycle completion pulse
//   wb_overflow_out     sticky: a column sample was dropped
module vpu_writeback_deskew #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 8,
   parameter int DEPTH      = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wb_start_in,
   input  logic [ADDR_WIDTH-1:0]   wb_base_addr_in,
   input  logic [ADDR_WIDTH-1:0]   wb_row_count_in,
   input  logic                    wb_valid_1_in,
   input  logic [DATA_WIDTH-1:0]   wb_data_1_in,
   input  logic                    wb_valid_2_in,
   input  logic [DATA_WIDTH-1:0]   wb_data_2_in,
   input  logic                    wb_ready_in,
   output logic                    wb_valid_out,
   output logic [2*DATA_WIDTH-1:0] wb_data_out,
   output logic [ADDR_WIDTH-1:0]   wb_addr_out,
   output logic                    wb_busy_out,
   output logic                    wb_done_out,
   output logic                    wb_overflow_out
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [PW:0]           PTR_ONE  = {{PW{1'b0}}, 1'b1};

   typedef enum logic {ST_IDLE, ST_RUN} state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   base_q, base_d;
   logic [ADDR_WIDTH-1:0]   count_q, count_d;
   logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
   logic                    valid_q, valid_d;
   logic [2*DATA_WIDTH-1:0] data_q, data_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic                    done_q, done_d;
   logic                    ovf_q, ovf_d;

   logic                    run, hs, last, pop, start_run, start_zero, clear;
   logic [1:0]              col_valid, col_avail, col_drop, col_empty, col_full;
   logic [DATA_WIDTH-1:0]   col_data [2];
   logic [DATA_WIDTH-1:0]   col_head [2];

   assign col_valid   = {wb_valid_2_in, wb_valid_1_in};
   assign col_data[0] = wb_data_1_in;
   assign col_data[1] = wb_data_2_in;

   assign run        = (state_q == ST_RUN);
   assign hs         = valid_q & wb_ready_in;
   assign last       = hs & (idx_q == count_q - ADDR_ONE);
   assign start_run  = ~run & wb_start_in & (wb_row_count_in != '0);
   assign start_zero = ~run & wb_start_in & (wb_row_count_in == '0);
   assign clear      = start_run | last;
   // No new pair is taken on the final handshake so the job never emits
   // more than the programmed number of rows.
   assign pop        = run & (&col_avail) & (~valid_q | hs) & ~last;

   // Per-column FIFO. When the FIFO is empty the incoming sample is visible
   // at the head directly, which gives one-cycle latency from the later
   // column's arrival to the row word.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_col
         logic [DATA_WIDTH-1:0] mem [DEPTH];
         logic [PW:0]           wptr_q, wptr_d, rptr_q, rptr_d;
         logic                  in_v, bypass, push, pop_fifo;

         assign in_v           = run & col_valid[gi];
         assign col_empty[gi]  = (wptr_q == rptr_q);
         assign col_full[gi]   = (wptr_q[PW] != rptr_q[PW]) &&
                                 (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
         assign col_avail[gi]  = ~col_empty[gi] | in_v;
         assign col_head[gi]   = col_empty[gi] ? col_data[gi] : mem[rptr_q[PW-1:0]];
         assign bypass         = pop & col_empty[gi];
         assign pop_fifo       = pop & ~col_empty[gi];
         assign push           = in_v & ~bypass & (~col_full[gi] | pop);
         assign col_drop[gi]   = in_v & ~bypass & col_full[gi] & ~pop;

         always_comb begin
            wptr_d = wptr_q;
            rptr_d = rptr_q;
            if (clear) begin
               wptr_d = '0;
               rptr_d = '0;
            end else begin
               if (push)     wptr_d = wptr_q + PTR_ONE;
               if (pop_fifo) rptr_d = rptr_q + PTR_ONE;
            end
         end

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               wptr_q <= '0;
               rptr_q <= '0;
            end else begin
               wptr_q <= wptr_d;
               rptr_q <= rptr_d;
            end
         end

         always_ff @(posedge clk) begin
            if (push) mem[wptr_q[PW-1:0]] <= col_data[gi];
         end
      end
   endgenerate

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start_run) state_d = ST_RUN;
         ST_RUN:  if (last)      state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Datapath / output next values
   always_comb begin
      base_d  = base_q;
      count_d = count_q;
      idx_d   = idx_q;
      valid_d = valid_q;
      data_d  = data_q;
      addr_d  = addr_q;
      done_d  = last | start_zero;
      ovf_d   = ovf_q;

      if (start_run) begin
         base_d  = wb_base_addr_in;
         count_d = wb_row_count_in;
         idx_d   = '0;
         valid_d = 1'b0;
      end else begin
         if (hs) idx_d = idx_q + ADDR_ONE;
         if (pop) begin
            valid_d = 1'b1;
            data_d  = {col_head[1], col_head[0]};
            // idx_q counts completed handshakes; the word being replaced
            // this cycle is one of them.
            addr_d  = base_q + idx_q + (hs ? ADDR_ONE : '0);
         end else if (hs) begin
            valid_d = 1'b0;
         end
      end

      if (start_run | start_zero) ovf_d = 1'b0;
      else if (|col_drop)         ovf_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         base_q  <= '0;
         count_q <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
         addr_q  <= '0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         count_q <= count_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         addr_q  <= addr_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
      end
   end

   // Output assignments
   always_comb begin
      wb_valid_out    = valid_q;
      wb_data_out     = data_q;
      wb_addr_out     = addr_q;
      wb_busy_out     = run;
      wb_done_out     = done_q;
      wb_overflow_out = ovf_q;
   end

endmodule

// File: tb/tb_vpu_writeback_deskew.sv
// tb_vpu_writeback_deskew
// Directed stimulus for vpu_writeback_deskew. A queue-based model of the
// job (two column queues, one output slot, row counter) predicts every
// output each cycle; literal expectations pin the model on the key
// scenarios. Inputs change 2 time units after the rising edge, outputs are
// sampled on the falling edge.
module tb_vpu_writeback_deskew;

   localparam int DEPTH = 4;

   logic        clk;
   logic        rst;
   logic        start;
   logic [7:0]  base_in, cnt_in;
   logic        v1, v2, rdy;
   logic [15:0] d1, d2;
   logic        wb_valid_out, wb_busy_out, wb_done_out, wb_overflow_out;
   logic [31:0] wb_data_out;
   logic [7:0]  wb_addr_out;

   int n_chk  = 0;
   int n_fail = 0;

   vpu_writeback_deskew #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .DEPTH(DEPTH)) dut (
      .clk             (clk),
      .rst             (rst),
      .wb_start_in     (start),
      .wb_base_addr_in (base_in),
      .wb_row_count_in (cnt_in),
      .wb_valid_1_in   (v1),
      .wb_data_1_in    (d1),
      .wb_valid_2_in   (v2),
      .wb_data_2_in    (d2),
      .wb_ready_in     (rdy),
      .wb_valid_out    (wb_valid_out),
      .wb_data_out     (wb_data_out),
      .wb_addr_out     (wb_addr_out),
      .wb_busy_out     (wb_busy_out),
      .wb_done_out     (wb_done_out),
      .wb_overflow_out (wb_overflow_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [15:0] q1[$];
   logic [15:0] q2[$];
   bit          m_run  = 0;
   bit          m_ov   = 0;
   bit          m_done = 0;
   bit          m_ovf  = 0;
   int          m_base = 0;
   int          m_cnt  = 0;
   int          m_idx  = 0;
   logic [31:0] m_word = '0;
   logic [7:0]  m_addr = '0;
   bit          m_hs, m_last, m_pop;

   always @(negedge rst) begin
      m_run = 0; m_ov = 0; m_done = 0; m_ovf = 0;
      m_idx = 0; q1.delete(); q2.delete();
   end

   always @(posedge clk) begin
      if (rst) begin
         m_hs   = m_ov && rdy;
         m_last = m_hs && (m_idx + 1 == m_cnt);
         m_done = 0;
         if (!m_run) begin
            if (start) begin
               m_ovf = 0;
               if (cnt_in != 0) begin
                  m_run = 1; m_base = int'(base_in); m_cnt = int'(cnt_in);
                  m_idx = 0; q1.delete(); q2.delete();
               end else begin
                  m_done = 1;
               end
            end
         end else begin
            m_pop = !m_last && (q1.size() > 0 || v1) && (q2.size() > 0 || v2) && (!m_ov || m_hs);
            if (v1) begin
               if (q1.size() < DEPTH || m_pop) q1.push_back(d1);
               else m_ovf = 1;
            end
            if (v2) begin
               if (q2.size() < DEPTH || m_pop) q2.push_back(d2);
               else m_ovf = 1;
            end
            if (m_hs) m_idx++;
            if (m_pop) begin
               m_word = {q2.pop_front(), q1.pop_front()};
               m_addr = 8'((m_base + m_idx) % 256);
               m_ov   = 1;
            end else if (m_hs) begin
               m_ov = 0;
            end
            if (m_last) begin
               m_run = 0; m_done = 1; m_ov = 0;
               q1.delete(); q2.delete();
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      check("valid", {63'd0, wb_valid_out}, {63'd0, m_ov});
      if (m_ov) begin
         check("data", {32'd0, wb_data_out}, {32'd0, m_word});
         check("addr", {56'd0, wb_addr_out}, {56'd0, m_addr});
      end
      check("busy", {63'd0, wb_busy_out}, {63'd0, m_run});
      check("done", {63'd0, wb_done_out}, {63'd0, m_done});
      check("overflow", {63'd0, wb_overflow_out}, {63'd0, m_ovf});
      if (wb_valid_out && wb_ready_in_sample())
         $display("row word %h @ %h", wb_data_out, wb_addr_out);
   end

   function automatic logic wb_ready_in_sample();
      return rdy;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic drive(input logic s, input logic [7:0] b, input logic [7:0] c,
                        input logic iv1, input logic [15:0] id1,
                        input logic iv2, input logic [15:0] id2, input logic r);
      @(posedge clk); #2;
      start = s; base_in = b; cnt_in = c;
      v1 = iv1; d1 = id1; v2 = iv2; d2 = id2; rdy = r;
      @(negedge clk);
   endtask

   task automatic cyc(input logic iv1, input logic [15:0] id1,
                      input logic iv2, input logic [15:0] id2, input logic r);
      drive(1'b0, 8'h00, 8'h00, iv1, id1, iv2, id2, r);
   endtask

   task automatic job(input logic [7:0] b, input logic [7:0] c, input logic r);
      drive(1'b1, b, c, 1'b0, 16'h0, 1'b0, 16'h0, r);
   endtask

   task automatic lit(input string name, input logic v, input logic [31:0] d, input logic [7:0] a);
      check({name, ".valid"}, {63'd0, wb_valid_out}, {63'd0, v});
      if (v) begin
         check({name, ".data"}, {32'd0, wb_data_out}, {32'd0, d});
         check({name, ".addr"}, {56'd0, wb_addr_out}, {56'd0, a});
      end
   endtask

   initial begin
      rst = 1'b1; start = 0; base_in = 0; cnt_in = 0;
      v1 = 0; v2 = 0; d1 = 0; d2 = 0; rdy = 0;
      #1 rst = 1'b0;
      @(negedge clk);
      lit("reset", 1'b0, 32'h0, 8'h0);
      check("reset.data0", {32'd0, wb_data_out}, 64'd0);
      check("reset.busy", {63'd0, wb_busy_out}, 64'd0);
      @(posedge clk); #2 rst = 1'b1;

      // Skewed stream
      job(8'h20, 8'd3, 1'b1);
      check("skew.busy_before", {63'd0, wb_busy_out}, 64'd0);
      cyc(1, 16'h0001, 0, 16'h0000, 1);
      check("skew.busy", {63'd0, wb_busy_out}, 64'd1);
      cyc(1, 16'h0002, 1, 16'hFFFF, 1);
      lit("skew.c1", 1'b0, 32'h0, 8'h0);
      cyc(1, 16'h0003, 1, 16'h8000, 1);
      lit("skew.w0", 1'b1, 32'hFFFF0001, 8'h20);
      cyc(0, 16'h0000, 1, 16'h7FFF, 1);
      lit("skew.w1", 1'b1, 32'h80000002, 8'h21);
      cyc(0, 16'h0000, 0, 16'h0000, 1);
      lit("skew.w2", 1'b1, 32'h7FFF0003, 8'h22);
      cyc(0, 16'h0000, 0, 16'h0000, 1);
      check("skew.done", {63'd0, wb_done_out}, 64'd1);
      check("skew.busy_end", {63'd0, wb_busy_out}, 64'd0);
      cyc(0, 16'h0000, 0, 16'h0000, 1);
      check("skew.done_pulse", {63'd0, wb_done_out}, 64'd0);

      // Backpressure
      job(8'h20, 8'd3, 1'b0);
      cyc(1, 16'h0001, 0, 16'h0000, 0);
      cyc(1, 16'h0002, 1, 16'hFFFF, 0);
      cyc(1, 16'h0003, 1, 16'h8000, 0);
      lit("bp.hold2", 1'b1, 32'hFFFF0001, 8'h20);
      cyc(0, 16'h0000, 1, 16'h7FFF, 0);
      lit("bp.hold3", 1'b1, 32'hFFFF0001, 8'h20);
      for (int i = 4; i <= 6; i++) begin
         cyc(0, 16'h0000, 0, 16'h0000, 0);
         lit("bp.hold", 1'b1, 32'hFFFF0001, 8'h20);
      end
      cyc(0, 16'h0000, 0, 16'h0000, 1);
      lit("bp.w0", 1'b1, 32'hFFFF0001, 8'h20);
      cyc(0, 16'h0000, 0, 16'h0000, 1);
      lit("bp.w1", 1'b1, 32'h80000002, 8'h21);
      cyc(0, 16'h0000, 0, 16'h0000, 1);
      lit("bp.w2", 1'b1, 32'h7FFF0003, 8'h22);
      check("bp.ovf", {63'd0, wb_overflow_out}, 64'd0);
      cyc(0, 16'h0000, 0, 16'h0000, 1);
      check("bp.done", {63'd0, wb_done_out}, 64'd1);

      // Overflow
      job(8'h30, 8'd2, 1'b0);
      for (int i = 0; i < 5; i++) begin
         cyc(1, 16'(16'h0100 + i), 0, 16'h0000, 0);
         check("ovf.before", {63'd0, wb_overflow_out}, 64'd0);
      end
      cyc(0, 16'h0000, 1, 16'hAAAA, 1);
      check("ovf.set", {63'd0, wb_overflow_out}, 64'd1);
      cyc(0, 16'h0000, 1, 16'hBBBB, 1);
      lit("ovf.w0", 1'b1, 32'hAAAA0100, 8'h30);
      cyc(0, 16'h0000, 0, 16'h0000, 1);
      lit("ovf.w1", 1'b1, 32'hBBBB0101, 8'h31);
      cyc(0, 16'h0000, 0, 16'h0000, 1);
      check("ovf.done", {63'd0, wb_done_out}, 64'd1);
      check("ovf.sticky", {63'd0, wb_overflow_out}, 64'd1);

      // Zero count: done next cycle, overflow cleared, busy never set
      job(8'h40, 8'd0, 1'b1);
      cyc(0, 16'h0000, 0, 16'h0000, 1);
      check("zero.done", {63'd0, wb_done_out}, 64'd1);
      check("zero.busy", {63'd0, wb_busy_out}, 64'd0);
      check("zero.ovf_clr", {63'd0, wb_overflow_out}, 64'd0);
      cyc(0, 16'h0000, 0, 16'h0000, 1);
      check("zero.done_pulse", {63'd0, wb_done_out}, 64'd0);

      // Address wrap
      job(8'hFE, 8'd3, 1'b1);
      cyc(1, 16'h0011, 1, 16'h0022, 1);
      cyc(1, 16'h0033, 1, 16'h0044, 1);
      lit("wrap.w0", 1'b1, 32'h00220011, 8'hFE);
      cyc(1, 16'h0055, 1, 16'h0066, 1);
      lit("wrap.w1", 1'b1, 32'h00440033, 8'hFF);
      cyc(0, 16'h0000, 0, 16'h0000, 1);
      lit("wrap.w2", 1'b1, 32'h00660055, 8'h00);
      cyc(0, 16'h0000, 0, 16'h0000, 1);
      check("wrap.done", {63'd0, wb_done_out}, 64'd1);

      // Valids in IDLE are discarded
      for (int i = 0; i < 6; i++) begin
         cyc(1, 16'h0005, 1, 16'h0006, 1);
         lit("idle.noout", 1'b0, 32'h0, 8'h0);
      end
      check("idle.ovf", {63'd0, wb_overflow_out}, 64'd0);

      // Start during RUN is ignored
      job(8'h60, 8'd2, 1'b1);
      cyc(1, 16'h0001, 1, 16'h0002, 1);
      drive(1'b1, 8'h50, 8'd5, 1'b1, 16'h0003, 1'b1, 16'h0004, 1'b1);
      lit("rerun.w0", 1'b1, 32'h00020001, 8'h60);
      cyc(0, 16'h0000, 0, 16'h0000, 1);
      lit("rerun.w1", 1'b1, 32'h00040003, 8'h61);
      cyc(0, 16'h0000, 0, 16'h0000, 1);
      check("rerun.done", {63'd0, wb_done_out}, 64'd1);

      // Reset mid-job
      job(8'h10, 8'd4, 1'b0);
      cyc(1, 16'h0001, 1, 16'h0002, 0);
      cyc(1, 16'h0003, 1, 16'h0004, 0);
      cyc(0, 16'h0000, 0, 16'h0000, 0);
      lit("mid.pre", 1'b1, 32'h00020001, 8'h10);
      @(posedge clk); #2 rst = 1'b0;
      #1;
      check("mid.valid0", {63'd0, wb_valid_out}, 64'd0);
      check("mid.data0", {32'd0, wb_data_out}, 64'd0);
      check("mid.addr0", {56'd0, wb_addr_out}, 64'd0);
      check("mid.busy0", {63'd0, wb_busy_out}, 64'd0);
      check("mid.done0", {63'd0, wb_done_out}, 64'd0);
      check("mid.ovf0", {63'd0, wb_overflow_out}, 64'd0);
      @(posedge clk); #2 rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc(1, 16'h0007, 1, 16'h0008, 1);
         lit("mid.after", 1'b0, 32'h0, 8'h0);
      end
      cyc(0, 16'h0000, 0, 16'h0000, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
